// File: rtl/nco_phase_sched_if.sv
// nco_phase_sched_if: start/result handshake between the NCO
// scheduler and a downstream sin/cos CORDIC.
interface nco_phase_sched_if;
  logic               cordic_trig;
  logic [9:0]         cordic_phase;
  logic               cordic_vld;
  logic signed [12:0] cordic_sin;
  logic signed [12:0] cordic_cos;

  // scheduler side: issues phases, receives results
  modport master (
    output cordic_trig,
    output cordic_phase,
    input  cordic_vld,
    input  cordic_sin,
    input  cordic_cos
  );

  // CORDIC side: accepts phases, returns results
  modport slave (
    input  cordic_trig,
    input  cordic_phase,
    output cordic_vld,
    output cordic_sin,
    output cordic_cos
  );
endinterface

// File: rtl/nco_phase_sched.sv
// nco_phase_sched: phase-accumulator NCO that keeps exactly one
// CORDIC sin/cos conversion in flight and registers each result.
module nco_phase_sched #(
  parameter int FTW_W   = 16,
  parameter int TIMEOUT = 100
) (
  input  logic               sys_clk,
  input  logic               sys_rst,
  input  logic               enable,
  input  logic               load,
  input  logic [9:0]         phase_init,
  input  logic [FTW_W-1:0]   ftw,
  nco_phase_sched_if.master  cordic,
  output logic               out_vld,
  output logic signed [12:0] sin_out,
  output logic signed [12:0] cos_out,
  output logic [9:0]         out_phase,
  output logic [15:0]        sample_cnt,
  output logic               timeout_err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;

  // timer only has to reach TIMEOUT-1 before it expires
  localparam int TMR_W =
    (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST =
    TMR_W'(TIMEOUT - 1);
  localparam logic [TMR_W-1:0] TMR_ONE =
    TMR_W'(1);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [FTW_W-1:0] acc;
  logic [FTW_W-1:0] acc_load;
  logic [TMR_W-1:0] timer;
  logic [9:0]       issued;
  logic             in_idle;
  logic             in_issue;
  logic             in_wait;
  logic             capture;
  logic             expire;

  assign in_idle  = (state == IDLE);
  assign in_issue = (state == ISSUE);
  assign in_wait  = (state == WAIT);

  // the top ten accumulator bits address the 1024-step circle
  assign issued   = acc[FTW_W-1 -: 10];
  assign acc_load = {phase_init, {(FTW_W-10){1'b0}}};

  // results only count while a conversion is outstanding
  assign capture = in_wait && cordic.cordic_vld;
  assign expire  = in_wait && !cordic.cordic_vld
                   && (timer == TMR_LAST);

  // the trigger lasts exactly the single ISSUE cycle
  assign cordic.cordic_trig  = in_issue;
  assign cordic.cordic_phase = in_issue ? issued : 10'd0;

  // next-state decode; load wins over enable in IDLE
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (!load && enable)
          state_nxt = ISSUE;
      end
      ISSUE: begin
        state_nxt = WAIT;
      end
      WAIT: begin
        if (capture)
          state_nxt = enable ? ISSUE : IDLE;
        else if (expire)
          state_nxt = ISSUE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // accumulator: loaded only when idle, advanced per result
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      acc <= '0;
    else if (in_idle && load)
      acc <= acc_load;
    else if (capture)
      acc <= acc + ftw;
  end

  // wait timer: restarts on every issue, counts while waiting
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      timer <= '0;
    else if (in_issue)
      timer <= '0;
    else if (in_wait && !capture)
      timer <= timer + TMR_ONE;
  end

  // sample registers hold their value between strobes
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sin_out   <= '0;
      cos_out   <= '0;
      out_phase <= '0;
    end else if (capture) begin
      sin_out   <= cordic.cordic_sin;
      cos_out   <= cordic.cordic_cos;
      out_phase <= issued;
    end
  end

  // strobe follows the accepted result by one cycle
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      out_vld <= 1'b0;
    else
      out_vld <= capture;
  end

  // delivered-sample counter, free-running modulo 2^16
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      sample_cnt <= '0;
    else if (capture)
      sample_cnt <= sample_cnt + 16'd1;
  end

  // sticky timeout flag, cleared only by reset
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst)
      timeout_err <= 1'b0;
    else if (expire)
      timeout_err <= 1'b1;
  end

endmodule

// File: tb/tb_nco_phase_sched.sv
// tb_nco_phase_sched: random-latency CORDIC responder plus a
// phase/sample scoreboard for the NCO scheduler.
module tb_nco_phase_sched;

  localparam int W   = 16;
  localparam int TMO = 100;
  localparam real PI = 3.141592653589793;

  logic               clk = 1'b0;
  logic               rst;
  logic               enable;
  logic               load;
  logic [9:0]         phase_init;
  logic [W-1:0]       ftw;
  logic               out_vld;
  logic signed [12:0] sin_out;
  logic signed [12:0] cos_out;
  logic [9:0]         out_phase;
  logic [15:0]        sample_cnt;
  logic               timeout_err;

  nco_phase_sched_if cif ();

  nco_phase_sched #(
    .FTW_W   (W),
    .TIMEOUT (TMO)
  ) dut (
    .sys_clk     (clk),
    .sys_rst     (rst),
    .enable      (enable),
    .load        (load),
    .phase_init  (phase_init),
    .ftw         (ftw),
    .cordic      (cif),
    .out_vld     (out_vld),
    .sin_out     (sin_out),
    .cos_out     (cos_out),
    .out_phase   (out_phase),
    .sample_cnt  (sample_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // reference model state
  longint             cyc = 0;
  longint             last_trig = 0;
  int                 trig_cnt = 0;
  int                 cnt_m = 0;
  logic [W-1:0]       acc_m = '0;
  bit                 outstanding = 0;
  bit                 chain = 0;
  bit                 tmo_m = 0;
  bit                 pending = 0;
  bit                 dropping = 0;
  bit                 drop_next = 0;
  bit                 spur_req = 0;
  bit                 spur_fire = 0;
  bit                 exp_vld = 0;
  int                 wait_cnt = 0;
  int                 last_lat = 0;
  int                 lat_min = 1;
  int                 lat_max = 1;
  logic [9:0]         pend_ph = '0;
  logic [9:0]         exp_ph = '0;
  logic signed [12:0] exp_sin = '0;
  logic signed [12:0] exp_cos = '0;
  logic [9:0]         hold_ph = '0;
  logic signed [12:0] hold_sin = '0;
  logic signed [12:0] hold_cos = '0;
  real                max_err = 0.0;
  logic [9:0]         seen[$];

  task automatic chk(input string tag,
                     input logic signed [63:0] got,
                     input logic signed [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic real ang(input logic [9:0] p);
    return 2.0 * PI * real'(p) / 1024.0;
  endfunction

  function automatic logic signed [12:0] q11(input real x);
    real y;
    int  r;
    y = x * 2048.0;
    r = (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(-y + 0.5);
    return 13'(r);
  endfunction

  function automatic real absr(input real x);
    return (x < 0.0) ? -x : x;
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // CORDIC responder and output scoreboard, sampled on negedge
  task automatic monitor();
    real e1, e2;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        if (out_vld || exp_vld)
          chk("out_vld", out_vld, exp_vld);
        if (exp_vld) begin
          hold_sin = exp_sin;
          hold_cos = exp_cos;
          hold_ph  = exp_ph;
          seen.push_back(out_phase);
          e1 = absr(real'(sin_out) / 2048.0 - $sin(ang(exp_ph)));
          e2 = absr(real'(cos_out) / 2048.0 - $cos(ang(exp_ph)));
          if (e1 > max_err) max_err = e1;
          if (e2 > max_err) max_err = e2;
        end
        chk("sin_out", sin_out, hold_sin);
        chk("cos_out", cos_out, hold_cos);
        chk("out_phase", out_phase, hold_ph);
        chk("sample_cnt", sample_cnt, cnt_m);
        if (!cif.cordic_trig)
          chk("phase_idle_zero", cif.cordic_phase, 0);
      end
      exp_vld = 0;
      cif.cordic_vld = 1'b0;
      if (spur_fire) begin
        spur_fire = 0;
        cif.cordic_vld = 1'b1;
        cif.cordic_sin = 13'sd1234;
        cif.cordic_cos = -13'sd99;
      end else if (pending) begin
        wait_cnt--;
        if (wait_cnt == 0) begin
          pending = 0;
          if (dropping) begin
            dropping = 0;
          end else begin
            cif.cordic_vld = 1'b1;
            cif.cordic_sin = q11($sin(ang(pend_ph)));
            cif.cordic_cos = q11($cos(ang(pend_ph)));
            if (outstanding) begin
              exp_vld = 1;
              exp_sin = cif.cordic_sin;
              exp_cos = cif.cordic_cos;
              exp_ph  = pend_ph;
              cnt_m++;
              acc_m = acc_m + ftw;
              outstanding = 0;
              chain = enable;
            end
          end
        end
      end
      if (spur_req) begin
        spur_req = 0;
        spur_fire = 1;
      end
      if (!rst && cif.cordic_trig) begin
        chk("trig_phase", cif.cordic_phase, acc_m[W-1 -: 10]);
        if (outstanding) begin
          chk("retrig_gap", cyc - last_trig, TMO + 1);
          tmo_m = 1;
        end else if (chain) begin
          chk("trig_gap", cyc - last_trig, last_lat + 1);
        end
        chain = 0;
        outstanding = 1;
        last_trig = cyc;
        trig_cnt++;
        pend_ph = cif.cordic_phase;
        last_lat = $urandom_range(lat_max, lat_min);
        wait_cnt = last_lat;
        pending = 1;
        dropping = drop_next;
        drop_next = 0;
      end
      if (!rst)
        chk("timeout_err", timeout_err, tmo_m);
    end
  endtask

  task automatic wait_trig(input int target, input int budget);
    int k = 0;
    while (trig_cnt < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_trig", trig_cnt, target);
  endtask

  task automatic wait_samples(input int target, input int budget);
    int k = 0;
    while (cnt_m < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("wait_samples", cnt_m, target);
  endtask

  task automatic do_reset();
    enable = 0;
    load = 0;
    rst = 1;
    acc_m = '0;
    cnt_m = 0;
    outstanding = 0;
    chain = 0;
    tmo_m = 0;
    exp_vld = 0;
    drop_next = 0;
    hold_sin = '0;
    hold_cos = '0;
    hold_ph = '0;
    #1;
    chk("rst_out_vld", out_vld, 0);
    chk("rst_sin", sin_out, 0);
    chk("rst_cos", cos_out, 0);
    chk("rst_out_phase", out_phase, 0);
    chk("rst_sample_cnt", sample_cnt, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_trig", cif.cordic_trig, 0);
    chk("rst_cordic_phase", cif.cordic_phase, 0);
    tick(3);
    rst = 0;
  endtask

  task automatic load_phase(input logic [9:0] p,
                            input logic [W-1:0] f);
    phase_init = p;
    ftw = f;
    load = 1;
    acc_m = {p, 6'd0};
    tick(1);
    load = 0;
  endtask

  initial begin
    int t0, c0, base, n, bad;
    rst = 1;
    enable = 0;
    load = 0;
    phase_init = '0;
    ftw = '0;
    cif.cordic_vld = 1'b0;
    cif.cordic_sin = '0;
    cif.cordic_cos = '0;
    fork
      monitor();
    join_none
    tick(1);
    do_reset();

    // fixed phase, fixed 14-cycle latency; load and enable together
    lat_min = 14;
    lat_max = 14;
    phase_init = 10'd256;
    ftw = '0;
    acc_m = {10'd256, 6'd0};
    load = 1;
    enable = 1;
    tick(1);
    load = 0;
    chk("load_prio_no_trig", cif.cordic_trig, 0);
    wait_samples(cnt_m + 5, 500);

    // enable dropped mid-transaction
    wait_trig(trig_cnt + 1, 100);
    tick(3);
    enable = 0;
    t0 = trig_cnt;
    wait_samples(cnt_m + 1, 100);
    tick(40);
    chk("no_trig_after_disable", trig_cnt, t0);

    // accumulator wrap
    lat_min = 1;
    lat_max = 6;
    base = seen.size();
    c0 = cnt_m;
    load_phase(10'd1020, 16'h0200);
    enable = 1;
    wait_trig(trig_cnt + 2, 200);
    enable = 0;
    wait_samples(c0 + 2, 50);
    tick(5);
    chk("wrap_count", seen.size(), base + 2);
    if (seen.size() >= base + 2) begin
      chk("wrap_ph0", seen[base], 1020);
      chk("wrap_ph1", seen[base + 1], 4);
    end

    // dropped result: timeout, same phase re-issued
    lat_min = 5;
    lat_max = 5;
    c0 = cnt_m;
    load_phase(10'd100, 16'h0400);
    drop_next = 1;
    enable = 1;
    t0 = trig_cnt;
    wait_trig(t0 + 1, 20);
    wait_trig(t0 + 2, TMO + 20);
    wait_trig(t0 + 3, 50);
    enable = 0;
    wait_samples(c0 + 2, 50);
    tick(20);
    chk("tmo_sticky", timeout_err, 1);
    n = seen.size();
    chk("tmo_ph_retry", seen[n - 2], 100);
    chk("tmo_ph_next", seen[n - 1], 116);

    // stray result while idle
    c0 = cnt_m;
    t0 = trig_cnt;
    spur_req = 1;
    tick(6);
    chk("spur_idle_cnt", sample_cnt, c0);
    chk("spur_idle_trig", trig_cnt, t0);

    // stray result during the issue cycle
    lat_min = 3;
    lat_max = 3;
    ftw = 16'($urandom);
    enable = 1;
    spur_req = 1;
    wait_trig(t0 + 1, 10);
    enable = 0;
    wait_samples(c0 + 1, 20);
    tick(8);
    chk("spur_issue_cnt", sample_cnt, c0 + 1);

    // random phases, increments and latencies
    lat_min = 1;
    lat_max = 8;
    repeat (4) begin
      n = $urandom_range(12, 3);
      c0 = cnt_m;
      t0 = trig_cnt;
      load_phase(10'($urandom), 16'($urandom));
      enable = 1;
      wait_trig(t0 + 2, 40);
      ftw = 16'($urandom);
      wait_trig(t0 + n, n * 20);
      enable = 0;
      wait_samples(c0 + n, 40);
      tick(3);
    end

    // reset while waiting; late result must be ignored
    lat_min = 10;
    lat_max = 10;
    load_phase(10'd50, 16'h0100);
    enable = 1;
    wait_trig(trig_cnt + 1, 10);
    tick(2);
    t0 = trig_cnt;
    do_reset();
    tick(15);
    chk("rst_late_cnt", sample_cnt, 0);
    chk("rst_late_ph", out_phase, 0);
    chk("rst_late_sin", sin_out, 0);
    chk("rst_late_trig", trig_cnt, t0);

    // full-circle sweep against sin/cos
    do_reset();
    lat_min = 1;
    lat_max = 3;
    max_err = 0.0;
    base = seen.size();
    t0 = trig_cnt;
    load_phase(10'd0, 16'h0040);
    enable = 1;
    wait_trig(t0 + 1024, 6000);
    enable = 0;
    wait_samples(1024, 20);
    tick(3);
    chk("sweep_cnt", sample_cnt, 1024);
    chk("sweep_seen", seen.size(), base + 1024);
    bad = 0;
    for (int i = 0; i < 1024; i++)
      if (base + i >= seen.size() || seen[base + i] != 10'(i))
        bad++;
    chk("sweep_order", bad, 0);
    chk("sweep_err", (max_err <= 1.0 / 512.0), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/nco_phase_sched.md
NCO_PHASE_SCHED -- requirements
Module: nco_phase_sched

Interface
- Parameters
REQ-001 The block SHALL have parameter FTW_W, default 16, giving the frequency tuning word and phase accumulator width.
REQ-002 The block SHALL have parameter TIMEOUT, default 100, giving the maximum cycles to wait for the CORDIC result.
- Ports
REQ-003 sys_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 sys_rst  in  1  asynchronous, active-high reset.
REQ-005 enable  in  1  level; run continuous phase generation.
REQ-006 load  in  1  pulse; load the start phase.
REQ-007 phase_init  in  10  start phase, in units of 2*pi/1024.
REQ-008 ftw  in  FTW_W  phase increment per sample, in units of 2*pi/2^FTW_W.
REQ-009 cordic_trig  out  1  one-cycle start pulse to the downstream sin/cos CORDIC.
REQ-010 cordic_phase  out  10  phase word to the CORDIC; valid while cordic_trig=1 and 0 otherwise.
REQ-011 cordic_vld  in  1  CORDIC result-valid pulse.
REQ-012 cordic_sin, cordic_cos  in  13 signed  CORDIC results, Q1.11.
REQ-013 out_vld  out  1  one-cycle sample strobe.
REQ-014 sin_out, cos_out  out  13 signed  registered samples, Q1.11.
REQ-015 out_phase  out  10  phase that produced the current sample.
REQ-016 sample_cnt  out  16  count of delivered samples.
REQ-017 timeout_err  out  1  sticky error flag.

Function
REQ-018 The FSM SHALL have three states: IDLE, ISSUE and WAIT.
REQ-019 acc (FTW_W bits) SHALL be the phase accumulator; the issued phase SHALL be acc[FTW_W-1:FTW_W-10].
REQ-020 IDLE: load=1 SHALL set acc={phase_init, zeros} and keep the FSM in IDLE; otherwise enable=1 SHALL move the FSM to ISSUE.
REQ-021 IDLE, load and enable both high: load SHALL take priority, and ISSUE SHALL follow on the next cycle if enable is still high.
REQ-022 load outside IDLE SHALL be ignored.
REQ-023 ISSUE: cordic_trig=1 and cordic_phase=issued phase for exactly one cycle; the WAIT timer SHALL clear and the FSM SHALL move to WAIT.
REQ-024 WAIT: on cordic_vld=1 the block SHALL capture cordic_sin, cordic_cos and the issued phase into sin_out, cos_out and out_phase.
REQ-025 On that capture, out_vld SHALL pulse exactly one cycle later, so output latency is 1 cycle from cordic_vld.
REQ-026 On that capture, sample_cnt SHALL increment, wrapping 0xFFFF->0, and acc SHALL advance by ftw modulo 2^FTW_W.
REQ-027 On that capture, the FSM SHALL go to ISSUE if enable=1, else to IDLE.
REQ-028 Trigger spacing SHALL be at least 2 cycles, with at most one transaction outstanding at any time.
REQ-029 WAIT with no cordic_vld for TIMEOUT cycles: timeout_err SHALL set, acc SHALL be held, and the FSM SHALL go to ISSUE to re-issue the same phase.
REQ-030 cordic_vld in IDLE or ISSUE SHALL be ignored: no capture, no count.
REQ-031 enable deasserted during WAIT SHALL let the outstanding transaction complete normally and then go to IDLE.
REQ-032 ftw changes SHALL take effect at the next accumulator advance; ftw=0 SHALL repeat the same phase.
REQ-033 sin_out, cos_out and out_phase SHALL hold between strobes.
REQ-034 timeout_err SHALL clear only on reset.

Reset
REQ-035 While sys_rst=1, asynchronously: FSM=IDLE, acc=0, cordic_trig=0, cordic_phase=0, out_vld=0, sin_out=0, cos_out=0, out_phase=0, sample_cnt=0, timeout_err=0.
REQ-036 Reset mid-transaction SHALL abandon it, and a late cordic_vld after reset release SHALL be ignored per REQ-030.

Verification
REQ-037 load with phase_init=256, ftw=0, enable=1, model returns vld 14 cycles after trig -> every cordic_phase=256, trig spacing 15 cycles, out_vld 1 cycle after each vld, sample_cnt increments.
REQ-038 phase_init=1020, ftw=0x0200 (8 phase steps), 2 samples -> phases 1020 then 4, showing wrap.
REQ-039 Model drops vld once, TIMEOUT=100 -> timeout_err=1 100 cycles after trig, same phase re-issued, acc not advanced, flag persists.
REQ-040 enable dropped 3 cycles after trig -> that sample still delivered, then IDLE with no further trig.
REQ-041 sys_rst asserted during WAIT, then vld arrives -> all outputs 0, no out_vld, sample_cnt=0.
REQ-042 Full sweep: ftw=0x0040, 1024 samples, checked against $sin/$cos -> max error <= 2^-9, sample_cnt=1024, out_phase = 0..1023 in order.
